if_id_fetch_stage: RTL and testbench



---
 rtl/if_id_fetch_stage.sv | 118 +++++++++++
 tb/tb_if_id_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch unit with IF/ID pipeline register for the RISC-V core.
// Single outstanding request to instruction memory; supports decode stall and EX redirect.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00010000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Target,
  output logic [31:0] Instr_ID,
  output logic [31:0] PC_ID,
  output logic        Valid_ID
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_buf, w_buf_nx;
  logic [31:0] r_instr, w_instr_nx;
  logic [31:0] r_pc_id, w_pc_id_nx;
  logic        r_valid, w_valid_nx;
  logic        r_drop, w_drop_nx;
  logic [31:0] w_pc_inc;
  logic [31:0] w_target;

  assign w_pc_inc = r_pc + 32'd4;
  assign w_target = Target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
      r_instr <= NOP_INSTR;
      r_pc_id <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_buf   <= w_buf_nx;
      r_instr <= w_instr_nx;
      r_pc_id <= w_pc_id_nx;
      r_valid <= w_valid_nx;
      r_drop  <= w_drop_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_buf_nx   = r_buf;
    w_instr_nx = r_instr;
    w_pc_id_nx = r_pc_id;
    w_valid_nx = r_valid;
    w_drop_nx  = r_drop;

    if (Redirect) begin
      // Outstanding request with no response yet must have its late Ack discarded.
      w_instr_nx = NOP_INSTR;
      w_valid_nx = 1'b0;
      w_pc_nx    = w_target;
      w_state_nx = S_WAIT;
      w_drop_nx  = (r_state == S_WAIT) && !IMem_Ack;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = S_WAIT;
        S_WAIT: begin
          if (IMem_Ack) begin
            if (r_drop) begin
              w_drop_nx = 1'b0;
            end else if (Stall) begin
              w_buf_nx   = IMem_Data;
              w_state_nx = S_HOLD;
            end else begin
              w_instr_nx = IMem_Data;
              w_pc_id_nx = r_pc;
              w_valid_nx = 1'b1;
              w_pc_nx    = w_pc_inc;
            end
          end else if (!Stall) begin
            w_instr_nx = NOP_INSTR;
            w_valid_nx = 1'b0;
          end
        end
        S_HOLD: begin
          // PC still addresses the buffered word; it advances only when it is handed on.
          if (!Stall) begin
            w_instr_nx = r_buf;
            w_pc_id_nx = r_pc;
            w_valid_nx = 1'b1;
            w_pc_nx    = w_pc_inc;
            w_state_nx = S_WAIT;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign IMem_Req  = (r_state == S_WAIT);
  assign IMem_Addr = r_pc;
  assign Instr_ID  = r_instr;
  assign PC_ID     = r_pc_id;
  assign Valid_ID  = r_valid;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: a memory model answers fetches and a
// monitor checks every instruction decode consumes against the expected stream.
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Target;
  logic [31:0] Instr_ID;
  logic [31:0] PC_ID;
  logic        Valid_ID;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] exp_q[$];
  int          lat = 2;
  int          mcnt = 0;
  logic [31:0] maddr = '0;

  if_id_fetch_stage #(
    .RESET_PC (32'h00010000),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .IMem_Req (IMem_Req),
    .IMem_Addr(IMem_Addr),
    .IMem_Ack (IMem_Ack),
    .IMem_Data(IMem_Data),
    .Stall    (Stall),
    .Redirect (Redirect),
    .Target   (Target),
    .Instr_ID (Instr_ID),
    .PC_ID    (PC_ID),
    .Valid_ID (Valid_ID)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00010000: return 32'hFD010113;
      32'h00010004: return 32'hF99FF0EF;
      32'h00010008: return 32'h0000B7B7;
      32'h0001000C: return 32'h00F00513;
      32'h00010144: return 32'h00A00593;
      32'h00020000: return 32'h00100093;
      32'hFFFFFFFC: return 32'hFFC00093;
      32'h00000000: return 32'h00200113;
      default:      return 32'hDEADBEEF ^ a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_q.push_back({instr, pc});
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!IMem_Req && n < 64);
    if (!IMem_Req) begin
      checks++;
      errors++;
      $display("FAIL timeout_req: no request seen");
    end
  endtask

  task automatic wait_ack(input logic [31:0] addr);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(IMem_Ack && IMem_Addr == addr) && n < 64);
    if (!(IMem_Ack && IMem_Addr == addr)) begin
      checks++;
      errors++;
      $display("FAIL timeout_ack: no ack at %08h", addr);
    end
  endtask

  // Memory model: latches the address when a request is first seen and acks
  // lat cycles later; Req held past an Ack starts a new request.
  initial begin
    IMem_Ack  = 1'b0;
    IMem_Data = '0;
    forever begin
      @(negedge clk);
      if (rst || !IMem_Req) begin
        IMem_Ack = 1'b0;
        mcnt     = 0;
      end else begin
        mcnt++;
        if (mcnt == 1) maddr = IMem_Addr;
        if (mcnt >= lat + 1) begin
          IMem_Ack  = 1'b1;
          IMem_Data = mem_word(maddr);
          mcnt      = 0;
        end else begin
          IMem_Ack = 1'b0;
        end
      end
    end
  end

  // Monitor: decode consumes IF/ID at the next edge when valid, not stalled, not squashed.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk); #2;
      if (!rst && Valid_ID && !Stall && !Redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got %08h at pc %08h expected none", Instr_ID, PC_ID);
        end else begin
          e = exp_q.pop_front();
          chk("id_instr", Instr_ID, e[63:32]);
          chk("id_pc", PC_ID, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Target = '0;
    #12;
    chk("rst_req", {31'd0, IMem_Req}, 32'd0);
    chk("rst_addr", IMem_Addr, 32'h00010000);
    chk("rst_instr", Instr_ID, 32'h00000013);
    chk("rst_pc_id", PC_ID, 32'h0);
    chk("rst_valid", {31'd0, Valid_ID}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    // First fetch with two-cycle latency, then a one-cycle-latency stream.
    push(32'hFD010113, 32'h00010000);
    push(32'hF99FF0EF, 32'h00010004);
    push(32'h0000B7B7, 32'h00010008);
    wait_req();
    chk("first_req_addr", IMem_Addr, 32'h00010000);
    wait_ack(32'h00010000);
    lat = 1;
    @(negedge clk); #1;
    chk("first_valid", {31'd0, Valid_ID}, 32'd1);
    chk("addr_after_first", IMem_Addr, 32'h00010004);
    wait_ack(32'h00010004);

    // Stall across the 0x10008 Ack: buffered in HOLD, released after stall drops.
    @(negedge clk); #1; Stall = 1'b1;
    @(negedge clk); #1;
    chk("stall_ack_seen", {31'd0, IMem_Ack}, 32'd1);
    chk("stall_hold_instr", Instr_ID, 32'hF99FF0EF);
    @(negedge clk); #1;
    chk("hold_req", {31'd0, IMem_Req}, 32'd0);
    chk("hold_instr", Instr_ID, 32'hF99FF0EF);
    @(negedge clk); #1;
    chk("hold_req2", {31'd0, IMem_Req}, 32'd0);
    @(negedge clk); #1; Stall = 1'b0;
    @(negedge clk); #1;
    chk("release_instr", Instr_ID, 32'h0000B7B7);
    chk("release_pc_id", PC_ID, 32'h00010008);
    chk("release_addr", IMem_Addr, 32'h0001000C);
    chk("release_req", {31'd0, IMem_Req}, 32'd1);

    // Redirect while 0x10010 is outstanding; its late data must be dropped.
    push(32'h00F00513, 32'h0001000C);
    wait_ack(32'h0001000C);
    lat = 3;
    @(negedge clk); #1;
    @(negedge clk); #1; Redirect = 1'b1; Target = 32'h00010146;
    @(negedge clk); #1; Redirect = 1'b0;
    chk("redir_valid", {31'd0, Valid_ID}, 32'd0);
    chk("redir_instr", Instr_ID, 32'h00000013);
    chk("redir_addr", IMem_Addr, 32'h00010144);
    chk("redir_req", {31'd0, IMem_Req}, 32'd1);
    push(32'h00A00593, 32'h00010144);
    wait_ack(32'h00010144);
    lat = 1;

    // Redirect coincident with Ack and Stall.
    push(32'h00100093, 32'h00020000);
    wait_ack(32'h00010148);
    Stall = 1'b1; Redirect = 1'b1; Target = 32'h00020000;
    @(negedge clk); #1;
    chk("coinc_valid", {31'd0, Valid_ID}, 32'd0);
    chk("coinc_instr", Instr_ID, 32'h00000013);
    chk("coinc_addr", IMem_Addr, 32'h00020000);
    chk("coinc_req", {31'd0, IMem_Req}, 32'd1);
    Stall = 1'b0; Redirect = 1'b0;

    // PC wrap: unaligned target at top of memory, then 0, then 4.
    push(32'hFFC00093, 32'hFFFFFFFC);
    push(32'h00200113, 32'h00000000);
    wait_ack(32'h00020000);
    @(negedge clk); #1;
    @(negedge clk); #1; Redirect = 1'b1; Target = 32'hFFFFFFFE;
    @(negedge clk); #1; Redirect = 1'b0;
    chk("wrap_addr", IMem_Addr, 32'hFFFFFFFC);
    wait_ack(32'h00000000);
    @(negedge clk); #1;
    chk("wrap_next_addr", IMem_Addr, 32'h00000004);

    // Asynchronous reset while a request is outstanding.
    @(negedge clk); #1; rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, IMem_Req}, 32'd0);
    chk("mid_rst_addr", IMem_Addr, 32'h00010000);
    chk("mid_rst_instr", Instr_ID, 32'h00000013);
    chk("mid_rst_pc_id", PC_ID, 32'h0);
    chk("mid_rst_valid", {31'd0, Valid_ID}, 32'd0);
    @(negedge clk); #1; rst = 1'b0;
    push(32'hFD010113, 32'h00010000);
    wait_req();
    chk("refetch_addr", IMem_Addr, 32'h00010000);
    wait_ack(32'h00010000);
    @(negedge clk); #3;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
